// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: small input FIFO feeding a start/data/parity/stop serialiser
// with per-frame parity and stop-length selection, timed by an external oversample tick.
module uart_tx_cfg #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned OS_TICK    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_tick,
    input  logic [DBIT-1:0]               din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [1:0]                    par_mode,
    input  logic [1:0]                    stop_mode,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned TickW = $clog2(2 * OS_TICK);
    localparam int unsigned BitW  = $clog2(DBIT);

    localparam logic [TickW-1:0] BitLast    = TickW'(OS_TICK - 1);
    localparam logic [TickW-1:0] Stop15Last = TickW'((OS_TICK * 3) / 2 - 1);
    localparam logic [TickW-1:0] Stop2Last  = TickW'(2 * OS_TICK - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0]   shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic [1:0]        stop_q, stop_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic [DBIT-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              push, pop;
    logic [TickW-1:0]  stop_last;

    // Ready comes from the registered count only, so a full FIFO never accepts a word.
    assign din_ready    = (count_q != (PtrW + 1)'(FIFO_DEPTH));
    assign push         = din_valid && din_ready;
    assign busy         = (state_q != StIdle);
    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign fifo_count   = count_q;

    always_comb begin
        case (stop_q)
            2'b00:   stop_last = BitLast;
            2'b01:   stop_last = Stop15Last;
            default: stop_last = Stop2Last;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
                    par_bit_d = (par_mode == 2'b10) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
                    stop_d    = stop_mode;
                    tick_d    = '0;
                    bit_d     = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (tick_q == BitLast) begin
                        tick_d  = '0;
                        state_d = StData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (tick_q == BitLast) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BitW'(DBIT - 1)) begin
                            state_d = par_en_q ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (s_tick) begin
                    if (tick_q == BitLast) begin
                        tick_d  = '0;
                        state_d = StStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (tick_q == stop_last) begin
                        tick_d  = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the state being entered, so it changes on the same edge.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= 2'b00;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frames are sampled mid-bit on the falling clock edge
// against hand-written bit patterns and stop lengths.
module tb_uart_tx_cfg;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] par_mode;
    logic [1:0] stop_mode;
    logic       tx;
    logic       busy;
    logic       tx_done_tick;
    logic [2:0] fifo_count;

    int checks;
    int failures;

    uart_tx_cfg #(
        .DBIT       (8),
        .OS_TICK    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .par_mode     (par_mode),
        .stop_mode    (stop_mode),
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns after the first falling edge that sees busy high.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 500);
        check_eq({tag, " start"}, busy, 1);
    endtask

    // Called on the falling edge right after the frame's start edge, with s_tick held high.
    task automatic check_frame(input string tag, input logic [11:0] bits, input int nb,
                               input int stop_ticks);
        bit ok;
        int cnt;
        repeat (8) @(negedge clk);
        for (int j = 0; j < nb; j++) begin
            check_eq($sformatf("%s bit%0d", tag, j), tx, bits[j]);
            if (j < nb - 1) repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        ok  = 1'b1;
        cnt = 0;
        while (!tx_done_tick && cnt < 100) begin
            if (tx !== 1'b1) ok = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check_eq({tag, " stop_len"}, cnt, stop_ticks);
        check_eq({tag, " stop_high"}, ok, 1);
        check_eq({tag, " busy_at_done"}, busy, 0);
    endtask

    task automatic send_one(input logic [7:0] w);
        int n;
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        wait_start("send", n);
        check_eq("send latency", n, 1);
    endtask

    initial begin
        int  n;
        bit  quiet;
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        s_tick    = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        par_mode  = 2'b00;
        stop_mode = 2'b00;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst tx", tx, 1);
        check_eq("rst busy", busy, 0);
        check_eq("rst din_ready", din_ready, 1);
        check_eq("rst fifo_count", fifo_count, 0);
        check_eq("rst done", tx_done_tick, 0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tick = ~s_tick;
            @(negedge clk);
            if (busy || !tx || tx_done_tick) quiet = 1'b0;
        end
        check_eq("idle quiet", quiet, 1);

        // 0xA5, no parity, 1 stop, with push-to-start latency
        s_tick    = 1'b1;
        din       = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("a5 count_after_push", fifo_count, 1);
        check_eq("a5 busy_before_pop", busy, 0);
        @(negedge clk);
        check_eq("a5 busy_after_pop", busy, 1);
        check_eq("a5 tx_after_pop", tx, 0);
        check_eq("a5 count_after_pop", fifo_count, 0);
        check_frame("a5", {8'hA5, 1'b0}, 9, 16);
        @(negedge clk);
        check_eq("a5 done_one_clk", tx_done_tick, 0);
        check_eq("a5 busy_after", busy, 0);

        // 0x07 even parity, 2 stop bits; then odd parity, 1.5 stop bits
        par_mode  = 2'b01;
        stop_mode = 2'b10;
        send_one(8'h07);
        check_frame("07even", {1'b1, 8'h07, 1'b0}, 10, 32);
        par_mode  = 2'b10;
        stop_mode = 2'b01;
        send_one(8'h07);
        check_frame("07odd", {1'b0, 8'h07, 1'b0}, 10, 24);

        // Overflow: fill the FIFO with the tick stopped
        par_mode  = 2'b00;
        stop_mode = 2'b00;
        repeat (2) @(negedge clk);
        s_tick    = 1'b0;
        din_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            din = 8'(k);
            @(negedge clk);
        end
        check_eq("ovf count", fifo_count, 4);
        check_eq("ovf ready", din_ready, 0);
        check_eq("ovf busy", busy, 1);
        s_tick = 1'b1;
        fork
            begin
                int w;
                for (w = 0; w < 3000 && din_ready !== 1'b1; w++) @(negedge clk);
                check_eq("ovf 06 ready", din_ready, 1);
                @(negedge clk);
                din_valid = 1'b0;
            end
            begin
                check_frame("ovf1", {8'h01, 1'b0}, 9, 16);
                for (int k = 2; k <= 6; k++) begin
                    wait_start($sformatf("ovf%0d", k), n);
                    check_eq($sformatf("ovf%0d idle_gap", k), n, 1);
                    check_frame($sformatf("ovf%0d", k), {8'(k), 1'b0}, 9, 16);
                end
            end
        join
        check_eq("ovf drained", fifo_count, 0);

        // Config change mid-frame applies only to the queued frame
        repeat (2) @(negedge clk);
        din       = 8'h3C;
        din_valid = 1'b1;
        @(negedge clk);
        din       = 8'h0B;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("cfg busy", busy, 1);
        fork
            begin
                repeat (40) @(negedge clk);
                par_mode = 2'b01;
            end
            check_frame("cfg3c", {8'h3C, 1'b0}, 9, 16);
        join
        wait_start("cfg0b", n);
        check_eq("cfg0b idle_gap", n, 1);
        check_frame("cfg0b", {1'b1, 8'h0B, 1'b0}, 10, 16);
        par_mode = 2'b00;

        // Reset during data bit 3 with two words queued
        repeat (2) @(negedge clk);
        din_valid = 1'b1;
        din       = 8'h11;
        @(negedge clk);
        din       = 8'h22;
        @(negedge clk);
        din       = 8'h33;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("mrst queued", fifo_count, 2);
        repeat (71) @(negedge clk);
        check_eq("mrst tx_bit3", tx, 0);
        reset_n = 1'b0;
        #1;
        check_eq("mrst tx", tx, 1);
        check_eq("mrst count", fifo_count, 0);
        check_eq("mrst busy", busy, 0);
        check_eq("mrst ready", din_ready, 1);
        check_eq("mrst done", tx_done_tick, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        quiet   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy || !tx || tx_done_tick) quiet = 1'b0;
        end
        check_eq("mrst quiet_after", quiet, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter: serialises DBIT-wide words from a small input FIFO onto `tx` with runtime-selectable parity and stop-bit length. It sits between a word-producing client (valid/ready handshake) and the pin. Bit timing comes from the shared baud-tick generator (`s_tick`, OS_TICK ticks per bit), the same tick the UART receiver uses.

## Interface
- DBIT, 8, data bits per frame (5..8)
- OS_TICK, 16, s_tick pulses per bit period (even, >=2)
- FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_tick  in  1  one-clk baud oversample strobe
- din  in  DBIT  word to send
- din_valid  in  1  din present this cycle
- din_ready  out  1  FIFO can accept a word
- par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop_mode  in  2  00 1 stop bit, 01 1.5, 10 2, 11 treated as 2
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress (state != IDLE)
- tx_done_tick  out  1  one-clk pulse at end of each frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO (excludes word being shifted)

## Operation
- FIFO: push when din_valid && din_ready at clock edge; din_ready = (fifo_count != FIFO_DEPTH), from registered count only (no pass-through when full, even if a pop occurs that cycle). Simultaneous push and pop: count unchanged. Order strictly FIFO.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If FIFO non-empty: pop head into shift register, latch par_mode/stop_mode into frame config, clear tick and bit counters, go START. s_tick ignored in IDLE, including the leaving cycle.
- START: tx=0 for OS_TICK s_ticks, then DATA.
- DATA: tx = shift[0], LSB first; after OS_TICK ticks shift right; after DBIT bits go PARITY if latched mode even/odd, else STOP.
- PARITY: tx = ^data (even) or ~^data (odd), computed on the popped word; OS_TICK ticks, then STOP.
- STOP: tx=1 for OS_TICK (1), OS_TICK*3/2 (1.5), or 2*OS_TICK (2) ticks; on the final tick go IDLE and pulse tx_done_tick.
- Config inputs affect only frames not yet started; changes mid-frame are ignored for the current frame.
- Tick counter wide enough for 2*OS_TICK-1; counts only on s_tick, resets to 0 at each state change.

## Timing
- Reset (async, reset_n=0): tx=1, busy=0, tx_done_tick=0, fifo_count=0, din_ready=1, state IDLE, FIFO contents and in-flight frame discarded; tx goes high immediately, not at next edge.
- Latency: word pushed into empty FIFO while IDLE at edge N → popped at edge N+1, tx falls and busy rises at edge N+1.
- Frame length in s_ticks: OS_TICK*(1+DBIT+P) + stop ticks, P=1 if parity enabled.
- tx_done_tick high for exactly one clk following the edge that consumes the final stop tick; busy falls on that same edge.
- Back-to-back: exactly one clk of IDLE (tx=1) between frames when FIFO non-empty; no s_tick required to start.
- s_tick held low: FSM freezes in current state, tx stable.

## Test plan
- Reset: hold reset_n=0, then release → tx=1, busy=0, din_ready=1, fifo_count=0, tx_done_tick=0; no activity with s_tick toggling and din_valid=0.
- Defaults, s_tick every clk, par none, stop 1, send 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clks; one tx_done_tick 160 ticks after start; busy low afterwards.
- Send 0x07 with even parity → parity bit 1; with odd → 0; stop_mode 10 → stop high 32 ticks; stop_mode 01 → 24 ticks.
- Overflow: s_tick=0, push 0x01..0x06 on consecutive clks → 0x01 popped, 0x02..0x05 held, fifo_count=4, din_ready=0, 0x06 held off; enable s_tick → 0x06 accepted after first tx_done_tick; six frames transmitted in order, one idle clk between each.
- Mid-frame config change: start 0x3C with par none, switch par_mode to 01 during DATA → current frame has no parity bit; next queued frame carries even parity.
- Reset mid-frame: pull reset_n low during DATA bit 3 with 2 words queued → tx=1 immediately, fifo_count=0, no tx_done_tick; after release line stays idle.
